// File: rtl/stopwatch_input_ctrl.sv
// Button/switch conditioning for the stopwatch counter: 2-flop sync, per-channel
// debounce, press pulses for the buttons and the pause/run toggle.
module stopwatch_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic but0,
  input  logic but1,
  input  logic sw0,
  input  logic sw1,
  output logic pause,
  output logic clr_pulse,
  output logic pause_pulse,
  output logic adj,
  output logic sel
);

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CH_BUT0 = 0;
  localparam int unsigned CH_BUT1 = 1;
  localparam int unsigned CH_SW0  = 2;
  localparam int unsigned CH_SW1  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0]            raw;
  logic [NUM_CH-1:0]            s1;
  logic [NUM_CH-1:0]            s2;
  logic [NUM_CH-1:0]            deb;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [1:0]                   deb_d;

  assign raw = {sw1, sw0, but1, but0};

  // Two-flop synchroniser for the asynchronous board inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge-delay registers and pause toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d <= '0;
      pause <= 1'b0;
    end else begin
      deb_d <= {deb[CH_BUT1], deb[CH_BUT0]};
      if (pause_pulse) begin
        pause <= ~pause;
      end
    end
  end

  // Rising-edge pulses are formed purely from registers, so they are glitch-free
  assign pause_pulse = deb[CH_BUT0] & ~deb_d[0];
  assign clr_pulse   = deb[CH_BUT1] & ~deb_d[1];
  assign adj         = deb[CH_SW0];
  assign sel         = deb[CH_SW1];

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Directed bench for stopwatch_input_ctrl: expected pulse cycles are queued when
// stimulus is driven and matched against the pulses the DUT emits.
module tb_stopwatch_input_ctrl;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst, but0, but1, sw0, sw1;
  logic pause, clr_pulse, pause_pulse, adj, sel;

  stopwatch_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .but0(but0), .but1(but1), .sw0(sw0), .sw1(sw1),
    .pause(pause), .clr_pulse(clr_pulse), .pause_pulse(pause_pulse),
    .adj(adj), .sel(sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic p_at;
    logic p_next;
  } exp_t;

  exp_t pq[$];
  exp_t cq[$];
  exp_t pe, ce;
  int   checks = 0;
  int   errors = 0;
  logic exp_pause = 1'b0;
  logic pp_pend = 1'b0, cp_pend = 1'b0;
  logic pp_val = 1'b0, cp_val = 1'b0;

  task automatic chk_bit(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw level driven at the negedge where cyc == c is sampled at edge c+1,
  // so the debounced level and its pulse are visible from cycle c+2+D.
  task automatic push_p(input int c);
    pq.push_back('{cyc: c + 2 + int'(D), p_at: exp_pause, p_next: ~exp_pause});
    exp_pause = ~exp_pause;
  endtask

  task automatic push_c(input int c, input logic at, input logic nxt);
    cq.push_back('{cyc: c + 2 + int'(D), p_at: at, p_next: nxt});
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((pq.size() != 0 || cq.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk_int("drain_pending", pq.size() + cq.size(), 0);
  endtask

  // Pulse monitor / scoreboard
  always @(negedge clk) begin
    if (pp_pend) begin
      chk_bit("pause_after_pp", pause, pp_val);
      pp_pend = 1'b0;
    end
    if (cp_pend) begin
      chk_bit("pause_after_cp", pause, cp_val);
      cp_pend = 1'b0;
    end
    if (pause_pulse === 1'b1) begin
      if (pq.size() == 0) begin
        chk_int("unexpected_pause_pulse", cyc, -1);
      end else begin
        pe = pq.pop_front();
        chk_int("pause_pulse_cycle", cyc, pe.cyc);
        chk_bit("pause_at_pp", pause, pe.p_at);
        pp_pend = 1'b1;
        pp_val  = pe.p_next;
      end
    end
    if (clr_pulse === 1'b1) begin
      if (cq.size() == 0) begin
        chk_int("unexpected_clr_pulse", cyc, -1);
      end else begin
        ce = cq.pop_front();
        chk_int("clr_pulse_cycle", cyc, ce.cyc);
        chk_bit("pause_at_cp", pause, ce.p_at);
        cp_pend = 1'b1;
        cp_val  = ce.p_next;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; but0 = 1'b0; but1 = 1'b0; sw0 = 1'b0; sw1 = 1'b0;
    tick(3);
    chk_bit("rst_pause", pause, 1'b0);
    chk_bit("rst_pause_pulse", pause_pulse, 1'b0);
    chk_bit("rst_clr_pulse", clr_pulse, 1'b0);
    chk_bit("rst_adj", adj, 1'b0);
    chk_bit("rst_sel", sel, 1'b0);
    rst = 1'b0;
    tick(10);
    chk_bit("idle_pause", pause, 1'b0);

    // Clean press, release, press again
    but0 = 1'b1; push_p(cyc);
    tick(20);
    but0 = 1'b0;
    tick(10);
    but0 = 1'b1; push_p(cyc);
    tick(20);
    but0 = 1'b0;
    drain(20);
    tick(10);
    chk_bit("clean_pause_final", pause, exp_pause);

    // Bounce on but1: 3-cycle highs are rejected, final hold accepted
    for (int k = 0; k < 2; k++) begin
      but1 = 1'b1; tick(3);
      but1 = 1'b0; tick(3);
    end
    but1 = 1'b1; push_c(cyc, exp_pause, exp_pause);
    tick(12);
    drain(20);
    but1 = 1'b0;
    tick(10);
    chk_bit("bounce_pause", pause, exp_pause);

    // Glitch on sw0 shorter than the debounce window
    sw0 = 1'b1; tick(3);
    sw0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_bit("glitch_adj", adj, 1'b0);
    end
    sw0 = 1'b1;
    tick(5);
    chk_bit("adj_before_accept", adj, 1'b0);
    tick(1);
    chk_bit("adj_accepted", adj, 1'b1);
    sw0 = 1'b0;
    tick(10);
    chk_bit("adj_released", adj, 1'b0);

    // Simultaneous but0/but1 press
    but0 = 1'b1; but1 = 1'b1;
    push_c(cyc, exp_pause, ~exp_pause);
    push_p(cyc);
    tick(15);
    but0 = 1'b0; but1 = 1'b0;
    drain(20);
    tick(10);
    chk_bit("simul_pause", pause, exp_pause);

    // Long hold on but0 with sw1 toggling underneath
    but0 = 1'b1; push_p(cyc);
    tick(100);
    sw1 = 1'b1;
    tick(5);
    chk_bit("sel_before_rise", sel, 1'b0);
    tick(1);
    chk_bit("sel_rise", sel, 1'b1);
    tick(100);
    sw1 = 1'b0;
    tick(5);
    chk_bit("sel_before_fall", sel, 1'b1);
    tick(1);
    chk_bit("sel_fall", sel, 1'b0);
    tick(1000 - 212);
    chk_bit("hold_pause", pause, exp_pause);
    but0 = 1'b0;
    drain(20);
    tick(10);
    chk_bit("hold_pause_after_release", pause, exp_pause);

    // All inputs high, then asynchronous reset mid-cycle with buttons held
    but0 = 1'b1; but1 = 1'b1; sw0 = 1'b1; sw1 = 1'b1;
    push_c(cyc, exp_pause, ~exp_pause);
    push_p(cyc);
    tick(15);
    drain(20);
    chk_bit("pre_rst_adj", adj, 1'b1);
    chk_bit("pre_rst_sel", sel, 1'b1);
    chk_bit("pre_rst_pause", pause, exp_pause);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_bit("async_rst_pause", pause, 1'b0);
    chk_bit("async_rst_pause_pulse", pause_pulse, 1'b0);
    chk_bit("async_rst_clr_pulse", clr_pulse, 1'b0);
    chk_bit("async_rst_adj", adj, 1'b0);
    chk_bit("async_rst_sel", sel, 1'b0);
    exp_pause = 1'b0;
    tick(3);
    rst = 1'b0;
    push_c(cyc, exp_pause, ~exp_pause);
    push_p(cyc);
    tick(15);
    drain(20);
    chk_bit("post_rst_pause", pause, 1'b1);
    chk_bit("post_rst_adj", adj, 1'b1);
    but0 = 1'b0; but1 = 1'b0; sw0 = 1'b0; sw1 = 1'b0;
    tick(15);
    chk_int("final_queues", pq.size() + cq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
- Input-conditioning stage directly upstream of the stopwatch time counter.
- Takes the raw board buttons and switches (but0, but1, sw0, sw1) and produces clean control signals for the counter:
  - two-flop synchronisation, then per-channel debounce;
  - single-cycle press pulses;
  - a pause/run toggle state.
- Runs on the master clock, not on the divided clocks, so button handling is independent of the 1 Hz count rate.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles needed to accept a new input level (5 ms at 100 MHz). Legal range is at least 1. The internal counter width is ceil(log2(DEBOUNCE_CYCLES+1)).

Ports:
- clk  input  1  master clock; the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- but0  input  1  raw pause/resume button, asynchronous to clk.
- but1  input  1  raw clear button, asynchronous to clk.
- sw0  input  1  raw adjust-mode switch.
- sw1  input  1  raw adjust-select switch (0 = minutes, 1 = seconds).
- pause  output  1  registered level; 1 = counter frozen.
- clr_pulse  output  1  one-cycle pulse on each accepted but1 press.
- pause_pulse  output  1  one-cycle pulse on each accepted but0 press.
- adj  output  1  debounced sw0 level.
- sel  output  1  debounced sw1 level.

Behaviour:
- Reset: on rst high, all of the following clear to 0 immediately, without waiting for clk:
  - sync flops, debounce counters and debounced levels;
  - edge-delay registers;
  - pause, clr_pulse, pause_pulse, adj, sel.
- Synchronisation: each of the 4 raw inputs passes through 2 flops (s1, s2). Only s2 is used downstream.
- Debounce, per channel (4 independent instances), with state = debounced level deb plus counter cnt:
  - s2 == deb: cnt <= 0.
  - s2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce back to deb restarts the count from 0. No glitch shorter than DEBOUNCE_CYCLES cycles reaches deb.
- Latency: a raw level held stable from the sampling edge E updates deb at edge E+1+DEBOUNCE_CYCLES. This is 2 sync stages plus DEBOUNCE_CYCLES counts, with the compare in the same cycle.
- Edge detect:
  - deb_d <= deb every cycle.
  - pause_pulse = deb_but0 & ~deb_d_but0; clr_pulse = the same for but1.
  - Both are combinational from registers, high for exactly the one cycle in which deb has just risen.
  - Releases (falling deb) produce no pulse.
- Pause toggle: at each clk edge where pause_pulse == 1, pause <= ~pause. There is no other writer.
- clr_pulse does not change pause.
- Switches: adj = deb_sw0 and sel = deb_sw1, unpulsed, with the same debounce latency as the buttons.
- Simultaneous events:
  - but0 and but1 accepted in the same cycle: both pulses assert together and pause toggles.
  - The channels never interact.
- Held button: exactly one pulse per press, regardless of hold length. The next pulse requires deb to fall and rise again, i.e. an accepted release followed by an accepted press.
- Reset mid-press: if a button is held through rst deassertion, it is treated as a new press. deb is 0 after reset, so deb rises DEBOUNCE_CYCLES+2 cycles after release and gives one pulse. Counting in progress at reset is discarded.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Test Plan (bench overrides DEBOUNCE_CYCLES = 4):
- Reset: assert rst mid-cycle with all inputs high. All outputs go to 0 immediately, asynchronously. Release rst with but0 held -> pause_pulse high for 1 cycle, 6 edges after release; pause = 1.
- Clean press: but0 0->1 held 20 cycles -> deb rises at E+5, pause_pulse is exactly 1 cycle wide, pause goes 0->1. Release, then press again -> second pulse, pause 1->0.
- Bounce rejection: but1 toggled 1,0,1,0 at 3-cycle intervals, then held high -> no clr_pulse during bouncing; one clr_pulse 5 edges after the final rising sample; pause unchanged.
- Glitch: 3-cycle high pulse on sw0 -> adj stays 0. 4-cycle-or-longer stable high -> adj = 1 at E+5.
- Simultaneous: but0 and but1 rise on the same edge and are held -> pause_pulse and clr_pulse high in the same cycle; pause toggles once.
- Long hold: but0 held 1000 cycles -> exactly one pause_pulse; sw1 toggled during the hold -> sel follows at E+5 and pause is unaffected.
